periph_pwm_multi: RTL and testbench

Memory-mapped multi-channel PWM peripheral, parametrised in channel count and counter width. All channels share one period counter. Each channel has its own duty, enable and polarity. Period and duty writes go to shadow registers and take effect only at a period boundary, so updates never glitch. It sits on the picomem peripheral bus beside the other simple word-addressed peripherals, and adds a sticky period-wrap flag with an interrupt output.

---
 rtl/periph_pwm_multi_pkg.sv | 13 +
 rtl/periph_pwm_multi_channel.sv | 61 ++++++
 rtl/periph_pwm_multi.sv | 168 ++++++++++++++++
 tb/tb_periph_pwm_multi.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/periph_pwm_multi_pkg.sv
// Shared register-map and CTRL bit-position constants for the multi-channel PWM peripheral.
package periph_pwm_pkg;

  localparam int unsigned ADDR_CTRL      = 32'd0;
  localparam int unsigned ADDR_PERIOD    = 32'd1;
  localparam int unsigned ADDR_STATUS    = 32'd2;
  localparam int unsigned ADDR_DUTY_BASE = 32'd4;

  localparam int unsigned RUN_BIT   = 32'd31;
  localparam int unsigned IRQEN_BIT = 32'd30;
  localparam int unsigned POL_LSB   = 32'd16;

endpackage

// File: rtl/periph_pwm_multi_channel.sv
// One PWM channel: duty shadow/active pair plus the registered compare against the shared counter.
module pwm_channel #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cnt_i,
  input  logic         wrap_i,
  input  logic         run_i,
  input  logic         en_i,
  input  logic         pol_i,
  input  logic         wr_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] duty_s_o,
  output logic         pwm_o
);

  logic [W-1:0] duty_s_q, duty_s_d;
  logic [W-1:0] duty_a_q, duty_a_d;
  logic         pwm_q, pwm_d;

  // Next-state: shadow capture, boundary-only active update, compare.
  always_comb begin
    duty_s_d = duty_s_q;
    duty_a_d = duty_a_q;
    pwm_d    = pwm_q;
    if (wr_i) begin
      duty_s_d = data_i;
    end else begin
      duty_s_d = duty_s_q;
    end
    // Stopped channels track the shadow so a fresh start uses the latest duty.
    if (!run_i || wrap_i) begin
      duty_a_d = duty_s_q;
    end else begin
      duty_a_d = duty_a_q;
    end
    if (run_i && en_i) begin
      pwm_d = (cnt_i < duty_a_q) ^ pol_i;
    end else begin
      pwm_d = pol_i;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_s_q <= '0;
      duty_a_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      duty_s_q <= duty_s_d;
      duty_a_q <= duty_a_d;
      pwm_q    <= pwm_d;
    end
  end

  assign duty_s_o = duty_s_q;
  assign pwm_o    = pwm_q;

endmodule

// File: rtl/periph_pwm_multi.sv
// Memory-mapped multi-channel PWM: register decode, CTRL, shared period counter, wrap flag and irq.
module periph_pwm_multi
  import periph_pwm_pkg::*;
#(
  parameter  int CH = 4,
  parameter  int W  = 16,
  localparam int AW = $clog2(CH + 4)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wrdata,
  input  logic          write,
  output logic [31:0]   rddata,
  output logic [CH-1:0] pwm,
  output logic          co,
  output logic          irq
);

  logic [31:0]   addr_w;
  logic          wr_ctrl_s, wr_period_s, wr_status_s;
  logic [CH-1:0] wr_duty_s;
  logic          wrap_s;
  logic [W-1:0]  duty_s [CH];
  logic [W-1:0]  duty_rd_s;
  logic          unused_wrdata_s;

  logic [CH-1:0] en_q, en_d;
  logic [CH-1:0] pol_q, pol_d;
  logic          irqen_q, irqen_d;
  logic          run_q, run_d;
  logic [W-1:0]  period_s_q, period_s_d;
  logic [W-1:0]  period_a_q, period_a_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic          status_q, status_d;

  assign addr_w          = 32'(addr);
  assign unused_wrdata_s = ^wrdata;
  assign wrap_s          = run_q && (cnt_q == period_a_q);

  // Write-strobe decode, one strobe per register.
  always_comb begin
    wr_ctrl_s   = write && (addr_w == ADDR_CTRL);
    wr_period_s = write && (addr_w == ADDR_PERIOD);
    wr_status_s = write && (addr_w == ADDR_STATUS);
    wr_duty_s   = '0;
    for (int i = 0; i < CH; i++) begin
      wr_duty_s[i] = write && (addr_w == ADDR_DUTY_BASE + 32'(i));
    end
  end

  // Next-state for CTRL, period pair, counter and sticky wrap flag.
  always_comb begin
    en_d       = en_q;
    pol_d      = pol_q;
    irqen_d    = irqen_q;
    run_d      = run_q;
    period_s_d = period_s_q;
    period_a_d = period_a_q;
    cnt_d      = cnt_q;
    status_d   = status_q;
    if (wr_ctrl_s) begin
      en_d    = wrdata[CH-1:0];
      pol_d   = wrdata[POL_LSB +: CH];
      irqen_d = wrdata[IRQEN_BIT];
      run_d   = wrdata[RUN_BIT];
    end else begin
      en_d    = en_q;
      pol_d   = pol_q;
      irqen_d = irqen_q;
      run_d   = run_q;
    end
    if (wr_period_s) begin
      period_s_d = wrdata[W-1:0];
    end else begin
      period_s_d = period_s_q;
    end
    if (!run_q || wrap_s) begin
      period_a_d = period_s_q;
    end else begin
      period_a_d = period_a_q;
    end
    if (!run_q || wrap_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
    // A wrap in the same cycle as a clear keeps the flag set.
    if (wrap_s) begin
      status_d = 1'b1;
    end else if (wr_status_s && wrdata[0]) begin
      status_d = 1'b0;
    end else begin
      status_d = status_q;
    end
  end

  // Control/status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q       <= '0;
      pol_q      <= '0;
      irqen_q    <= 1'b0;
      run_q      <= 1'b0;
      period_s_q <= '0;
      period_a_q <= '0;
      cnt_q      <= '0;
      status_q   <= 1'b0;
    end else begin
      en_q       <= en_d;
      pol_q      <= pol_d;
      irqen_q    <= irqen_d;
      run_q      <= run_d;
      period_s_q <= period_s_d;
      period_a_q <= period_a_d;
      cnt_q      <= cnt_d;
      status_q   <= status_d;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    pwm_channel #(.W(W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .cnt_i    (cnt_q),
      .wrap_i   (wrap_s),
      .run_i    (run_q),
      .en_i     (en_q[g]),
      .pol_i    (pol_q[g]),
      .wr_i     (wr_duty_s[g]),
      .data_i   (wrdata[W-1:0]),
      .duty_s_o (duty_s[g]),
      .pwm_o    (pwm[g])
    );
  end

  // Duty readback select; out-of-range addresses fall through to zero.
  always_comb begin
    duty_rd_s = '0;
    for (int i = 0; i < CH; i++) begin
      if (addr_w == ADDR_DUTY_BASE + 32'(i)) begin
        duty_rd_s = duty_s[i];
      end else begin
        duty_rd_s = duty_rd_s;
      end
    end
  end

  // Combinational read mux.
  always_comb begin
    rddata = 32'd0;
    case (addr_w)
      ADDR_CTRL: begin
        rddata[CH-1:0]         = en_q;
        rddata[POL_LSB +: CH]  = pol_q;
        rddata[IRQEN_BIT]      = irqen_q;
        rddata[RUN_BIT]        = run_q;
      end
      ADDR_PERIOD: rddata[W-1:0] = period_s_q;
      ADDR_STATUS: rddata[0]     = status_q;
      default:     rddata[W-1:0] = duty_rd_s;
    endcase
  end

  assign co  = wrap_s;
  assign irq = status_q && irqen_q;

endmodule

// File: tb/tb_periph_pwm_multi.sv
// Scoreboard bench for periph_pwm_multi: stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_periph_pwm_multi;

  localparam int CH = 4;
  localparam int W  = 16;
  localparam int AW = $clog2(CH + 4);

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic [31:0]   wrdata;
  logic          write;
  logic [31:0]   rddata;
  logic [CH-1:0] pwm;
  logic          co;
  logic          irq;

  always #5 clk = ~clk;

  periph_pwm_multi #(.CH(CH), .W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wrdata (wrdata),
    .write  (write),
    .rddata (rddata),
    .pwm    (pwm),
    .co     (co),
    .irq    (irq)
  );

  typedef struct {
    string       tag;
    logic [3:0]  pwm_m;
    logic [3:0]  pwm_e;
    logic        co_c;
    logic        co_e;
    logic        irq_c;
    logic        irq_e;
    logic        rd_c;
    logic [31:0] rd_e;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   kk = 0;

  // Monitor: one expectation per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      if (mon_e.pwm_m != 4'd0) begin
        n_checks++;
        if ((pwm & mon_e.pwm_m) !== mon_e.pwm_e) begin
          n_errors++;
          $display("FAIL %s pwm: got %b want %b (mask %b)", mon_e.tag, pwm & mon_e.pwm_m, mon_e.pwm_e, mon_e.pwm_m);
        end
      end
      if (mon_e.co_c) begin
        n_checks++;
        if (co !== mon_e.co_e) begin
          n_errors++;
          $display("FAIL %s co: got %b want %b", mon_e.tag, co, mon_e.co_e);
        end
      end
      if (mon_e.irq_c) begin
        n_checks++;
        if (irq !== mon_e.irq_e) begin
          n_errors++;
          $display("FAIL %s irq: got %b want %b", mon_e.tag, irq, mon_e.irq_e);
        end
      end
      if (mon_e.rd_c) begin
        n_checks++;
        if (rddata !== mon_e.rd_e) begin
          n_errors++;
          $display("FAIL %s rddata: got %h want %h", mon_e.tag, rddata, mon_e.rd_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    kk++;
  endtask

  task automatic push(input string tag, input logic [3:0] pm, input logic [3:0] pe,
                      input logic cc, input logic ce, input logic ic, input logic ie,
                      input logic rc, input logic [31:0] re);
    exp_t e;
    e.tag = tag; e.pwm_m = pm; e.pwm_e = pe; e.co_c = cc; e.co_e = ce;
    e.irq_c = ic; e.irq_e = ie; e.rd_c = rc; e.rd_e = re;
    sb_q.push_back(e);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    addr   = AW'(a);
    wrdata = d;
    write  = 1'b1;
    tick();
    write  = 1'b0;
  endtask

  task automatic tick_to(input int r);
    for (int i = 0; i < 12 && (kk % 10) != r; i++) tick();
  endtask

  // PERIOD=9: duty 3 for the first period, 7 for the next two (the co-cycle write is deferred), then 2.
  function automatic logic exp_pwm0(input int k);
    int p, c, d;
    if (k == 0) return 1'b0;
    p = (k - 1) / 10;
    c = (k - 1) % 10;
    d = (p == 0) ? 3 : ((p <= 2) ? 7 : 2);
    return (c < d);
  endfunction

  initial begin
    rst = 1'b1; write = 1'b0; addr = '0; wrdata = 32'd0;
    tick(); tick();
    rst = 1'b0;

    // Reset state: every address reads 0, outputs idle.
    for (int a = 0; a < 8; a++) begin
      addr = AW'(a);
      push("reset_rd", 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
      tick();
    end
    wr(3, 32'hFFFF_FFFF);
    wr(2, 32'hFFFF_FFFF);
    addr = AW'(3); push("rsvd_rd", 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0); tick();
    addr = AW'(2); push("stat_rd0", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0); tick();
    addr = AW'(0); push("ctrl_rd0", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0); tick();

    // Program and start channel 0.
    wr(1, 32'hFFFF_0009);
    wr(4, 32'd3);
    addr = AW'(1); push("period_rd", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0009); tick();
    addr = AW'(4); push("duty0_rd", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3); tick();
    wr(0, 32'h8000_0001);
    kk = 0;

    // Steady run plus a mid-period and a co-cycle DUTY0 update.
    while (kk < 40) begin
      push("run", 4'hF, {3'b000, exp_pwm0(kk)}, 1'b1, ((kk % 10) == 9), 1'b1, 1'b0, 1'b0, 32'd0);
      if (kk == 2)  begin addr = AW'(4); wrdata = 32'd7; write = 1'b1; end
      if (kk == 19) begin addr = AW'(4); wrdata = 32'd2; write = 1'b1; end
      tick();
      write = 1'b0;
    end

    // Inverted polarity with zero duty holds pwm[1] high.
    wr(0, 32'h8002_0003);
    tick();
    for (int i = 0; i < 12; i++) begin
      push("pol_duty0", 4'hE, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
    end
    // Duty above period gives 100% once loaded at the boundary.
    wr(5, 32'd15);
    wr(0, 32'h8000_0003);
    tick_to(2); tick_to(0); tick();
    for (int i = 0; i < 12; i++) begin
      push("duty_full", 4'hE, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
    end
    wr(0, 32'h8000_0001);
    push("en_off_lag", 4'hE, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      push("en_off", 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
    end

    // Interrupt: rise after wrap, clear off-wrap, set wins on wrap.
    tick_to(3);
    wr(2, 32'd1);
    wr(0, 32'hC000_0001);
    addr = AW'(0);
    for (int i = 0; i < 6; i++) begin
      push("irq_rise", 4'h0, 4'h0, 1'b1, ((kk % 10) == 9), 1'b1, ((kk % 10) == 0), 1'b1, 32'hC000_0001);
      tick();
    end
    addr = AW'(2);
    push("irq_held", 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1);
    tick(); tick();
    wr(2, 32'd1);
    push("irq_clr", 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
    tick();
    tick_to(9);
    addr = AW'(2); wrdata = 32'd1; write = 1'b1;
    push("irq_wrapclr", 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    write = 1'b0;
    push("irq_setwins", 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1);
    tick();
    push("irq_stays", 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    tick();

    // Mid-run reset at cnt=5.
    tick_to(5);
    rst = 1'b1;
    push("pre_rst", 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    rst = 1'b0;
    for (int a = 0; a < 6; a++) begin
      addr = AW'(a);
      push("post_rst", 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
      tick();
    end
    addr = AW'(0);
    for (int i = 0; i < 20; i++) begin
      push("idle", 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
    if (sb_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
